// File: rtl/alu_bitserial_ctrl.sv
// Bit-serial ALU sequencer. Latches two WIDTH-bit operands and a 3-bit op, then
// drives an external combinational 1-bit ALU slice one bit per clock, LSB first.
// It collects the slice result and carry each cycle, builds the full result, and
// derives the zero, carry and overflow flags.
//
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   start, op_in         request (sampled only when idle) and ALU operation
//   a_in, b_in           operands, latched when start is accepted
//   slice_a, slice_b     current operand bits
//   slice_binvert        B-invert select (op[2])
//   slice_cin            carry into the current bit
//   slice_less           Less input of the slice (tied 0)
//   slice_op             slice result-mux select
//   slice_result/carry   combinational slice outputs for the current bit
//   busy, done           running / one-cycle completion pulse
//   result, zero, carry_out, overflow  final result and flags, held until next op
module alu_bitserial_ctrl #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_binvert,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [1:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        op_q;
  logic [CntW-1:0]   cnt_q;
  // Holds bits 0..WIDTH-2; the MSB is taken straight from the slice on the last edge.
  logic [WIDTH-2:0]  res_q;
  logic              carry_q;

  logic              run;
  logic              last_bit;
  logic              is_arith;
  logic              ovf;
  logic [WIDTH-1:0]  res_full;
  logic [WIDTH-1:0]  res_final;

  assign run      = (state_q == StRun);
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign is_arith = (op_q == 3'b010) || (op_q == 3'b110) || (op_q == 3'b111);

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Final result; valid only during the last RUN cycle. carry_q is the MSB carry-in.
  always_comb begin
    res_full  = {slice_result, res_q};
    ovf       = is_arith & (carry_q ^ slice_carry);
    res_final = res_full;
    // SLT: sign of a-b corrected by overflow gives signed less-than.
    if (op_q == 3'b111) res_final = {{(WIDTH - 1){1'b0}}, slice_result ^ ovf};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        a_q     <= a_in;
        b_q     <= b_in;
        op_q    <= op_in;
        cnt_q   <= '0;
        res_q   <= '0;
        carry_q <= op_in[2];
      end
      if (run) begin
        res_q   <= {slice_result, res_q[WIDTH-2:1]};
        carry_q <= slice_carry;
        cnt_q   <= cnt_q + 1'b1;
        if (last_bit) begin
          result    <= res_final;
          zero      <= (res_final == '0);
          carry_out <= slice_carry;
          overflow  <= ovf;
        end
      end
    end
  end

  // Slice drive is held quiet outside RUN.
  always_comb begin
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_binvert = 1'b0;
    slice_cin     = 1'b0;
    slice_op      = 2'b00;
    if (run) begin
      slice_a       = a_q[cnt_q];
      slice_b       = b_q[cnt_q];
      slice_binvert = op_q[2];
      slice_cin     = carry_q;
      slice_op      = (op_q == 3'b111) ? 2'b10 : op_q[1:0];
    end
  end

  assign slice_less = 1'b0;
  assign busy       = run;
  assign done       = (state_q == StDone);

endmodule
